// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN call scheduler for a five-floor car.
// Latches call buttons, clears served floors after a door dwell, and picks the next target floor.
module elevator_call_scheduler #(
  parameter int DOOR_HOLD = 4,
  parameter int CNT_W     = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] call_req_i,
  input  logic [2:0] current_floor_i,
  input  logic       door_open_i,
  output logic [2:0] target_floor_o,
  output logic       target_valid_o,
  output logic [4:0] pending_o,
  output logic [1:0] sweep_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [4:0]         pending_q, pending_d;
  logic [2:0]         target_q, target_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         prev_floor_q;

  logic               floor_ok;
  logic [2:0]         f_idx;
  logic [4:0]         floor_oh;
  logic [4:0]         ge_mask, le_mask;
  logic [4:0]         above, below;
  logic               cur_pend;
  logic               floor_changed;
  logic [CNT_W-1:0]   cnt_eff;
  logic               hold_done;
  logic               dwell_ok;
  logic [4:0]         clr_mask;

  function automatic logic [2:0] lowest_floor(input logic [4:0] m);
    logic [2:0] r;
    r = 3'd1;
    for (int i = 4; i >= 0; i--) begin
      if (m[i]) r = 3'(i + 1);
    end
    return r;
  endfunction

  function automatic logic [2:0] highest_floor(input logic [4:0] m);
    logic [2:0] r;
    r = 3'd1;
    for (int i = 0; i <= 4; i++) begin
      if (m[i]) r = 3'(i + 1);
    end
    return r;
  endfunction

  // Floor codes 0, 6 and 7 yield an all-zero one-hot, which disables both clear and steering.
  assign floor_ok = (current_floor_i >= 3'd1) && (current_floor_i <= 3'd5);
  assign f_idx    = current_floor_i - 3'd1;
  assign floor_oh = floor_ok ? (5'b00001 << f_idx) : 5'b00000;
  assign le_mask  = (floor_oh - 5'd1) | floor_oh;
  assign ge_mask  = ~(floor_oh - 5'd1);
  assign above    = pending_q & ge_mask;
  assign below    = pending_q & le_mask;
  assign cur_pend = |(pending_q & floor_oh);

  // Arriving at a new floor restarts the dwell from zero on this very edge.
  assign floor_changed = (current_floor_i != prev_floor_q);
  assign cnt_eff       = floor_changed ? '0 : cnt_q;
  assign hold_done     = (cnt_eff == CNT_W'(DOOR_HOLD - 1));
  assign dwell_ok      = floor_ok && door_open_i && cur_pend;
  assign clr_mask      = (dwell_ok && hold_done) ? floor_oh : 5'b00000;

  always_comb begin
    cnt_d = '0;
    if (dwell_ok && !hold_done) begin
      if (cnt_eff < CNT_W'(DOOR_HOLD)) cnt_d = cnt_eff + CNT_W'(1);
      else                             cnt_d = cnt_eff;
    end
  end

  assign pending_d = (pending_q & ~clr_mask) | call_req_i;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    valid_d  = |pending_q;
    if (floor_ok) begin
      unique case (state_q)
        S_IDLE: begin
          if (pending_q != 5'b00000) begin
            if (above != 5'b00000) begin
              state_d  = S_UP;
              target_d = lowest_floor(above);
            end else begin
              state_d  = S_DOWN;
              target_d = highest_floor(below);
            end
          end
        end
        S_UP: begin
          if (above != 5'b00000) begin
            target_d = lowest_floor(above);
          end else if (below != 5'b00000) begin
            state_d  = S_DOWN;
            target_d = highest_floor(below);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DOWN: begin
          if (below != 5'b00000) begin
            target_d = highest_floor(below);
          end else if (above != 5'b00000) begin
            state_d  = S_UP;
            target_d = lowest_floor(above);
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pending_q    <= 5'b00000;
      target_q     <= 3'b001;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
      prev_floor_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      target_q     <= target_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      prev_floor_q <= current_floor_i;
    end
  end

  assign target_floor_o = target_q;
  assign target_valid_o = valid_q;
  assign pending_o      = pending_q;
  assign sweep_state_o  = state_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - scoreboard bench for elevator_call_scheduler.
// Directed vectors push expected post-edge outputs; a negedge monitor pops and compares.
module tb_elevator_call_scheduler;

  typedef struct packed {
    logic       rst;
    logic [4:0] call;
    logic [2:0] floor;
    logic       door;
    logic [4:0] pend;
    logic [1:0] st;
    logic [2:0] tgt;
    logic       vld;
  } vec_t;

  typedef struct {
    int   idx;
    vec_t v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] call_req;
  logic [2:0] current_floor;
  logic       door_open;
  logic [2:0] target_floor;
  logic       target_valid;
  logic [4:0] pending;
  logic [1:0] sweep_state;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  elevator_call_scheduler #(.DOOR_HOLD(4), .CNT_W(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .call_req_i     (call_req),
    .current_floor_i(current_floor),
    .door_open_i    (door_open),
    .target_floor_o (target_floor),
    .target_valid_o (target_valid),
    .pending_o      (pending),
    .sweep_state_o  (sweep_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [4:0] c, input logic [2:0] f, input logic d,
                     input logic [4:0] p, input logic [1:0] s, input logic [2:0] t, input logic v);
    vec_t x;
    x.rst = r; x.call = c; x.floor = f; x.door = d;
    x.pend = p; x.st = s; x.tgt = t; x.vld = v;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pending",      e.idx, {3'b0, pending},      {3'b0, e.v.pend});
      check("sweep_state",  e.idx, {6'b0, sweep_state},  {6'b0, e.v.st});
      check("target_floor", e.idx, {5'b0, target_floor}, {5'b0, e.v.tgt});
      check("target_valid", e.idx, {7'b0, target_valid}, {7'b0, e.v.vld});
    end
  end

  initial begin
    rst = 1'b1; call_req = 5'b0; current_floor = 3'd1; door_open = 1'b0;

    // reset
    add(1, 5'b00000, 3'd1, 0, 5'b00000, 2'b00, 3'd1, 0);
    add(1, 5'b00000, 3'd1, 0, 5'b00000, 2'b00, 3'd1, 0);
    // calls at floors 3 and 5 from floor 1
    add(0, 5'b10100, 3'd1, 0, 5'b10100, 2'b00, 3'd1, 0);
    add(0, 5'b00000, 3'd1, 0, 5'b10100, 2'b01, 3'd3, 1);
    add(0, 5'b00000, 3'd2, 0, 5'b10100, 2'b01, 3'd3, 1);
    add(0, 5'b00000, 3'd3, 0, 5'b10100, 2'b01, 3'd3, 1);
    // dwell four cycles at floor 3
    for (int i = 0; i < 3; i++) add(0, 5'b00000, 3'd3, 1, 5'b10100, 2'b01, 3'd3, 1);
    add(0, 5'b00000, 3'd3, 1, 5'b10000, 2'b01, 3'd3, 1);
    add(0, 5'b00000, 3'd3, 0, 5'b10000, 2'b01, 3'd5, 1);
    // call behind the sweep at floor 2
    add(0, 5'b00010, 3'd3, 0, 5'b10010, 2'b01, 3'd5, 1);
    add(0, 5'b00000, 3'd4, 0, 5'b10010, 2'b01, 3'd5, 1);
    add(0, 5'b00000, 3'd5, 0, 5'b10010, 2'b01, 3'd5, 1);
    for (int i = 0; i < 3; i++) add(0, 5'b00000, 3'd5, 1, 5'b10010, 2'b01, 3'd5, 1);
    add(0, 5'b00000, 3'd5, 1, 5'b00010, 2'b01, 3'd5, 1);
    add(0, 5'b00000, 3'd5, 0, 5'b00010, 2'b10, 3'd2, 1);
    add(0, 5'b00000, 3'd4, 0, 5'b00010, 2'b10, 3'd2, 1);
    add(0, 5'b00000, 3'd3, 0, 5'b00010, 2'b10, 3'd2, 1);
    add(0, 5'b00000, 3'd2, 0, 5'b00010, 2'b10, 3'd2, 1);
    // interrupted dwell: high 2, low 1, high 2, low 1
    add(0, 5'b00000, 3'd2, 1, 5'b00010, 2'b10, 3'd2, 1);
    add(0, 5'b00000, 3'd2, 1, 5'b00010, 2'b10, 3'd2, 1);
    add(0, 5'b00000, 3'd2, 0, 5'b00010, 2'b10, 3'd2, 1);
    add(0, 5'b00000, 3'd2, 1, 5'b00010, 2'b10, 3'd2, 1);
    add(0, 5'b00000, 3'd2, 1, 5'b00010, 2'b10, 3'd2, 1);
    add(0, 5'b00000, 3'd2, 0, 5'b00010, 2'b10, 3'd2, 1);
    // four consecutive clears it
    for (int i = 0; i < 3; i++) add(0, 5'b00000, 3'd2, 1, 5'b00010, 2'b10, 3'd2, 1);
    add(0, 5'b00000, 3'd2, 1, 5'b00000, 2'b10, 3'd2, 1);
    add(0, 5'b00000, 3'd2, 0, 5'b00000, 2'b00, 3'd2, 0);
    // set wins over clear at floor 3
    add(0, 5'b00100, 3'd3, 0, 5'b00100, 2'b00, 3'd2, 0);
    for (int i = 0; i < 3; i++) add(0, 5'b00000, 3'd3, 1, 5'b00100, 2'b01, 3'd3, 1);
    add(0, 5'b00100, 3'd3, 1, 5'b00100, 2'b01, 3'd3, 1);
    add(0, 5'b00000, 3'd3, 0, 5'b00100, 2'b01, 3'd3, 1);
    // calls everywhere, already-pending floor 3 unaffected
    add(0, 5'b11011, 3'd3, 0, 5'b11111, 2'b01, 3'd3, 1);
    // invalid floor codes hold everything
    add(0, 5'b00000, 3'd0, 1, 5'b11111, 2'b01, 3'd3, 1);
    add(0, 5'b00000, 3'd6, 1, 5'b11111, 2'b01, 3'd3, 1);
    // dwell restarts at floor 3, clears after four
    for (int i = 0; i < 3; i++) add(0, 5'b00000, 3'd3, 1, 5'b11111, 2'b01, 3'd3, 1);
    add(0, 5'b00000, 3'd3, 1, 5'b11011, 2'b01, 3'd3, 1);
    add(0, 5'b00000, 3'd3, 0, 5'b11011, 2'b01, 3'd4, 1);
    // reset mid-sweep discards requests
    add(1, 5'b00000, 3'd4, 0, 5'b00000, 2'b00, 3'd1, 0);
    add(0, 5'b00000, 3'd4, 0, 5'b00000, 2'b00, 3'd1, 0);
    // downward start, later call ahead does not reverse
    add(0, 5'b00001, 3'd4, 0, 5'b00001, 2'b00, 3'd1, 0);
    add(0, 5'b00000, 3'd4, 0, 5'b00001, 2'b10, 3'd1, 1);
    add(0, 5'b10000, 3'd3, 0, 5'b10001, 2'b10, 3'd1, 1);
    add(0, 5'b00000, 3'd2, 0, 5'b10001, 2'b10, 3'd1, 1);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      exp_t e;
      rst           = vecs[i].rst;
      call_req      = vecs[i].call;
      current_floor = vecs[i].floor;
      door_open     = vecs[i].door;
      @(posedge clk);
      e.idx = i;
      e.v   = vecs[i];
      exp_q.push_back(e);
      #1;
    end
    rst = 1'b0; call_req = 5'b0; door_open = 1'b0;

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Upstream stage of the elevator floor controller. Latches floor call buttons into a pending-request register and runs a SCAN policy: keep sweeping in one direction while requests remain ahead, then reverse. Drives the controller's target_floor input. Clears a served request once the door has been held open at that floor for a programmable dwell time.

Parameters:
DOOR_HOLD, 4, consecutive door_open cycles at a pending floor required to clear that request (legal range 1..7)
CNT_W, 3, width of the dwell counter; must satisfy 2^CNT_W > DOOR_HOLD

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
call_req  input  5  call buttons, bit i = floor i+1; level or pulse, sampled every edge
current_floor  input  3  floor the car is at, encoding 3'b001..3'b101 = floors 1..5
door_open  input  1  door status from the floor controller
target_floor  output  3  registered target floor for the floor controller, same encoding
target_valid  output  1  registered; 1 while any request is pending
pending  output  5  registered pending-request mask
sweep_state  output  2  registered scheduler state: 00 IDLE, 01 UP, 10 DOWN

Behaviour:
- Reset (rst=1 at an edge): pending=0, sweep_state=IDLE, target_floor=3'b001, target_valid=0, dwell counter=0. Reset mid-sweep discards all requests.
- Call capture: pending_next = (pending & ~clr_mask) | call_req. Set wins over clear for the same bit. Latency: call at edge N shows in pending after edge N; target reflects it after edge N+1.
- Floor index f = current_floor-1. current_floor outside 1..5 is invalid: no clear, dwell counter forced to 0, sweep_state and target hold.
- Dwell counter: increments while door_open=1 and pending[f]=1. Resets to 0 when door_open=0, pending[f]=0, or current_floor changes from the previous cycle. Saturates at DOOR_HOLD.
- Clear: clr_mask has bit f set on the edge where the counter already equals DOOR_HOLD-1 and door_open=1. The counter then returns to 0.
- The state machine and target are computed from the registered pending and current_floor. Both are registered together.
  above = pending bits at floors >= current; below = pending bits at floors <= current.
  IDLE: pending==0 -> stay, target_valid=0, target_floor holds. Else if above!=0 -> UP. Else -> DOWN.
  UP: above!=0 -> stay UP, target_floor = lowest pending floor >= current. Else below!=0 -> DOWN, target = highest pending floor <= current. Else -> IDLE.
  DOWN: mirror of UP. Highest pending floor <= current. Else the lowest pending floor above -> UP. Else -> IDLE.
- target_valid = (pending != 0) registered alongside target_floor.
- A request at the current floor makes target_floor = current_floor. The floor controller then opens the door.
- New calls behind the sweep do not change direction until no requests remain ahead.
- call_req for a floor already pending has no effect. Calls at all five floors at once are all captured.

Test Plan:
1. rst=1 for 2 cycles -> pending=00000, sweep_state=00, target_floor=001, target_valid=0.
2. current_floor=001, call_req=10100 for 1 cycle -> next edge pending=10100; following edge sweep_state=01, target_floor=011, target_valid=1.
3. Continue: current_floor=011, door_open=1 for 4 cycles -> pending=10000 after the 4th edge; next edge target_floor=101, sweep_state=01.
4. UP toward 101 with call_req=00010 injected at floor 3 -> target stays 101. After floor 5 is served (door_open 4 cycles) -> sweep_state=10, target_floor=010.
5. At floor 2 pending, door_open high 2 cycles, low 1, high 2 -> bit not cleared. Then high 4 consecutive cycles -> cleared, target_valid=0, sweep_state=00.
6. On the clearing edge at floor 3, call_req=00100 -> pending[2] stays 1. Separately, rst=1 mid-sweep with pending=11011 -> all outputs at reset values after that edge.
